// File: rtl/inld.sv
// inld -- input loader for the input-buffer pipeline.
//
// Runs after the eraser has cleared the M*nIR*nIC input buffer. Copies an
// M x R x C feature map from the source memory into that buffer. Each map is
// placed at row/column offset P, so the P-wide border keeps its zeros and
// acts as padding. The buffer write port (in_we/in_wa/in_wd) follows the
// same convention as the eraser; the top level selects between the two by
// looking at done.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              start request, only honoured while idle (done = 1)
//   M, R, C         number of maps, source rows per map, source columns per map
//   P               padding width
//   nIR, nIC        buffer rows / columns per map (R+2P, C+2P)
//   done            1 while idle or finished
//   src_re, src_ra  source read enable / linear read address
//   src_rd          source read data, valid the cycle after src_re
//   in_we, in_wa    buffer write enable / write address (registered)
//   in_wd           buffer write data, passed straight through from src_rd
//
// Geometry inputs are not captured; they must stay stable from the start
// request until done returns high.

module inld #(
    parameter int DATA_SIZE = 16,
    parameter int MEM_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] M,
    input  logic [DATA_SIZE-1:0] R,
    input  logic [DATA_SIZE-1:0] C,
    input  logic [DATA_SIZE-1:0] P,
    input  logic [DATA_SIZE-1:0] nIR,
    input  logic [DATA_SIZE-1:0] nIC,
    output logic                 done,
    output logic                 src_re,
    output logic [MEM_SIZE-1:0]  src_ra,
    input  logic [DATA_SIZE-1:0] src_rd,
    output logic                 in_we,
    output logic [MEM_SIZE-1:0]  in_wa,
    output logic [DATA_SIZE-1:0] in_wd
);

    typedef enum logic [1:0] {
        ST_DONE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [DATA_SIZE-1:0] ONE_D = 1;
    localparam logic [MEM_SIZE-1:0]  ONE_M = 1;

    state_t               state_q, state_d;
    logic                 done_q, done_d;
    logic                 src_re_q, src_re_d;
    logic [MEM_SIZE-1:0]  src_ra_q, src_ra_d;
    logic                 in_we_q, in_we_d;
    logic [MEM_SIZE-1:0]  in_wa_q, in_wa_d;

    // Coordinates of the element being read in the current cycle.
    logic [DATA_SIZE-1:0] m_q, m_d;
    logic [DATA_SIZE-1:0] r_q, r_d;
    logic [DATA_SIZE-1:0] c_q, c_d;

    // map_base = m*nIR*nIC, row_base = map_base + r*nIC. Both advance by
    // addition only as the counters wrap.
    logic [MEM_SIZE-1:0]  map_base_q, map_base_d;
    logic [MEM_SIZE-1:0]  row_base_q, row_base_d;

    logic [MEM_SIZE-1:0]  nic_w, nir_w, p_w;
    logic [MEM_SIZE-1:0]  map_stride, pad_off, cur_addr;
    logic                 zero_size, last_c, last_r, last_m;

    assign nic_w = MEM_SIZE'(nIC);
    assign nir_w = MEM_SIZE'(nIR);
    assign p_w   = MEM_SIZE'(P);

    // Static strides derived from the held geometry. They do not depend on
    // the running counters, so no per-element multiply is needed.
    assign map_stride = nir_w * nic_w;
    assign pad_off    = p_w * nic_w + p_w;

    assign cur_addr  = row_base_q + pad_off + MEM_SIZE'(c_q);

    assign zero_size = (M == '0) || (R == '0) || (C == '0);
    assign last_c    = (c_q == C - ONE_D);
    assign last_r    = (r_q == R - ONE_D);
    assign last_m    = (m_q == M - ONE_D);

    // Next-state logic. The write side always trails the read side by one
    // cycle: whatever was read last cycle is written this cycle, addressed by
    // the coordinates that were current during that read.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        src_re_d   = 1'b0;
        src_ra_d   = src_ra_q;
        in_we_d    = src_re_q;
        in_wa_d    = src_re_q ? cur_addr : '0;
        m_d        = m_q;
        r_d        = r_q;
        c_d        = c_q;
        map_base_d = map_base_q;
        row_base_d = row_base_q;

        case (state_q)
            ST_DONE: begin
                if (en) begin
                    done_d     = 1'b0;
                    src_ra_d   = '0;
                    m_d        = '0;
                    r_d        = '0;
                    c_d        = '0;
                    map_base_d = '0;
                    row_base_d = '0;
                    // An empty map still drops done for one cycle so the
                    // caller sees a completed handshake.
                    if (zero_size) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d  = ST_LOAD;
                        src_re_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (last_c && last_r && last_m) begin
                    state_d  = ST_DRAIN;
                    src_ra_d = '0;
                end else begin
                    src_re_d = 1'b1;
                    src_ra_d = src_ra_q + ONE_M;
                    if (!last_c) begin
                        c_d = c_q + ONE_D;
                    end else begin
                        c_d = '0;
                        if (!last_r) begin
                            r_d        = r_q + ONE_D;
                            row_base_d = row_base_q + nic_w;
                        end else begin
                            r_d        = '0;
                            m_d        = m_q + ONE_D;
                            map_base_d = map_base_q + map_stride;
                            row_base_d = map_base_q + map_stride;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                m_d        = '0;
                r_d        = '0;
                c_d        = '0;
                map_base_d = '0;
                row_base_d = '0;
            end

            default: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        endcase
    end

    // All state and outputs are registered; reset abandons any load in
    // progress and returns to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            src_re_q   <= 1'b0;
            src_ra_q   <= '0;
            in_we_q    <= 1'b0;
            in_wa_q    <= '0;
            m_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            map_base_q <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            src_re_q   <= src_re_d;
            src_ra_q   <= src_ra_d;
            in_we_q    <= in_we_d;
            in_wa_q    <= in_wa_d;
            m_q        <= m_d;
            r_q        <= r_d;
            c_q        <= c_d;
            map_base_q <= map_base_d;
            row_base_q <= row_base_d;
        end
    end

    assign done   = done_q;
    assign src_re = src_re_q;
    assign src_ra = src_ra_q;
    assign in_we  = in_we_q;
    assign in_wa  = in_wa_q;
    assign in_wd  = src_rd;

endmodule

// File: tb/tb_inld.sv
// tb_inld -- testbench for the input loader.
//
// A small source memory answers reads one cycle after src_re. A monitor logs
// every read address and every buffer write. Expected writes come from the
// direct formula m*nIR*nIC + (r+P)*nIC + (c+P) over nested loops.

module tb_inld;

    localparam int DS = 16;
    localparam int MS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DS-1:0] M, R, C, P, nIR, nIC;
    logic          done;
    logic          src_re;
    logic [MS-1:0] src_ra;
    logic [DS-1:0] src_rd;
    logic          in_we;
    logic [MS-1:0] in_wa;
    logic [DS-1:0] in_wd;

    int checks;
    int passes;

    logic [DS-1:0] src_mem [256];

    int wa_q[$];
    int wd_q[$];
    int ra_q[$];
    int exp_a[$];
    int exp_d[$];

    always #5 clk = ~clk;

    inld #(.DATA_SIZE(DS), .MEM_SIZE(MS)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .M      (M),
        .R      (R),
        .C      (C),
        .P      (P),
        .nIR    (nIR),
        .nIC    (nIC),
        .done   (done),
        .src_re (src_re),
        .src_ra (src_ra),
        .src_rd (src_rd),
        .in_we  (in_we),
        .in_wa  (in_wa),
        .in_wd  (in_wd)
    );

    // Source memory: one-cycle read latency.
    always @(posedge clk) begin
        if (src_re === 1'b1) src_rd <= src_mem[src_ra[7:0]];
    end

    // Monitor: log reads and buffer writes away from the active edge.
    always @(negedge clk) begin
        if (in_we === 1'b1) begin
            wa_q.push_back(int'(in_wa));
            wd_q.push_back(int'(in_wd));
        end
        if (src_re === 1'b1) ra_q.push_back(int'(src_ra));
    end

    task automatic fill_src();
        for (int i = 0; i < 256; i++) src_mem[i] = DS'($urandom_range(0, 65535));
    endtask

    // Reference model: every source element lands at its padded position.
    task automatic build_expected(input int mn, input int rn, input int cn,
                                  input int pn, input int nir, input int nic);
        exp_a.delete();
        exp_d.delete();
        for (int m = 0; m < mn; m++)
            for (int r = 0; r < rn; r++)
                for (int c = 0; c < cn; c++) begin
                    exp_a.push_back((m * nir * nic + (r + pn) * nic + c + pn) & 32'hFFFF);
                    exp_d.push_back(int'(src_mem[(m * rn + r) * cn + c]));
                end
    endtask

    // Drives a start request; returns at the sampling point of cycle 1.
    task automatic start_load(input int mn, input int rn, input int cn,
                              input int pn, input int nir, input int nic,
                              input bit hold);
        @(negedge clk);
        M   = DS'(mn);
        R   = DS'(rn);
        C   = DS'(cn);
        P   = DS'(pn);
        nIR = DS'(nir);
        nIC = DS'(nic);
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) en = 1'b0;
    endtask

    // Counts cycles until done is seen high, bounded by limit.
    task automatic wait_done(input int start, input int limit, output int cyc);
        cyc = start;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL reset_done: got %b expected 1", done); else passes++;
        checks++; if (src_re !== 1'b0) $display("[TB] FAIL reset_src_re: got %b expected 0", src_re); else passes++;
        checks++; if (src_ra !== '0) $display("[TB] FAIL reset_src_ra: got %0d expected 0", src_ra); else passes++;
        checks++; if (in_we !== 1'b0) $display("[TB] FAIL reset_in_we: got %b expected 0", in_we); else passes++;
        checks++; if (in_wa !== '0) $display("[TB] FAIL reset_in_wa: got %0d expected 0", in_wa); else passes++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || src_re !== 1'b0) $display("[TB] FAIL idle_after_reset: got done=%b src_re=%b expected 1/0", done, src_re); else passes++;
    endtask

    task automatic test_basic();
        int ea[4] = '{5, 6, 9, 10};
        int ed[4] = '{10, 11, 12, 13};
        int cyc, got;
        fill_src();
        for (int i = 0; i < 4; i++) src_mem[i] = DS'(10 + i);
        start_load(1, 2, 2, 1, 4, 4, 1'b0);
        checks++; if (done !== 1'b0) $display("[TB] FAIL basic_busy: got done=%b expected 0", done); else passes++;
        wait_done(1, 40, cyc);
        checks++; if (cyc != 6) $display("[TB] FAIL basic_done_cycle: got %0d expected 6", cyc); else passes++;
        checks++; if (wa_q.size() != 4) $display("[TB] FAIL basic_write_count: got %0d expected 4", wa_q.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            got = (i < ra_q.size()) ? ra_q[i] : -1;
            checks++; if (got != i) $display("[TB] FAIL basic_ra[%0d]: got %0d expected %0d", i, got, i); else passes++;
            got = (i < wa_q.size()) ? wa_q[i] : -1;
            checks++; if (got != ea[i]) $display("[TB] FAIL basic_wa[%0d]: got %0d expected %0d", i, got, ea[i]); else passes++;
            got = (i < wd_q.size()) ? wd_q[i] : -1;
            checks++; if (got != ed[i]) $display("[TB] FAIL basic_wd[%0d]: got %0d expected %0d", i, got, ed[i]); else passes++;
        end
        checks++; if (in_wa !== '0 || in_we !== 1'b0) $display("[TB] FAIL basic_idle_port: got we=%b wa=%0d expected 0/0", in_we, in_wa); else passes++;
    endtask

    task automatic test_multi_map();
        int cyc, got;
        fill_src();
        start_load(2, 2, 2, 0, 2, 2, 1'b0);
        wait_done(1, 60, cyc);
        checks++; if (cyc != 10) $display("[TB] FAIL multi_done_cycle: got %0d expected 10", cyc); else passes++;
        checks++; if (ra_q.size() != 8) $display("[TB] FAIL multi_read_count: got %0d expected 8", ra_q.size()); else passes++;
        checks++; if (wa_q.size() != 8) $display("[TB] FAIL multi_write_count: got %0d expected 8", wa_q.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            got = (i < wa_q.size()) ? wa_q[i] : -1;
            checks++; if (got != i) $display("[TB] FAIL multi_wa[%0d]: got %0d expected %0d", i, got, i); else passes++;
            got = (i < wd_q.size()) ? wd_q[i] : -1;
            checks++; if (got != int'(src_mem[i])) $display("[TB] FAIL multi_wd[%0d]: got %0d expected %0d", i, got, src_mem[i]); else passes++;
        end
    endtask

    task automatic test_wrap();
        int ea[6] = '{16, 17, 18, 51, 52, 53};
        int cyc, got;
        fill_src();
        start_load(2, 1, 3, 2, 5, 7, 1'b0);
        wait_done(1, 60, cyc);
        checks++; if (cyc != 8) $display("[TB] FAIL wrap_done_cycle: got %0d expected 8", cyc); else passes++;
        checks++; if (wa_q.size() != 6) $display("[TB] FAIL wrap_write_count: got %0d expected 6", wa_q.size()); else passes++;
        for (int i = 0; i < 6; i++) begin
            got = (i < wa_q.size()) ? wa_q[i] : -1;
            checks++; if (got != ea[i]) $display("[TB] FAIL wrap_wa[%0d]: got %0d expected %0d", i, got, ea[i]); else passes++;
            got = (i < wd_q.size()) ? wd_q[i] : -1;
            checks++; if (got != int'(src_mem[i])) $display("[TB] FAIL wrap_wd[%0d]: got %0d expected %0d", i, got, src_mem[i]); else passes++;
        end
    endtask

    task automatic test_zero_size();
        int dims[3][3] = '{'{0, 2, 2}, '{1, 0, 2}, '{1, 2, 0}};
        for (int k = 0; k < 3; k++) begin
            start_load(dims[k][0], dims[k][1], dims[k][2], 0, dims[k][1], dims[k][2], 1'b0);
            checks++; if (done !== 1'b0) $display("[TB] FAIL zero%0d_busy: got done=%b expected 0", k, done); else passes++;
            @(negedge clk);
            checks++; if (done !== 1'b1) $display("[TB] FAIL zero%0d_done: got done=%b expected 1", k, done); else passes++;
            repeat (2) @(negedge clk);
            checks++; if (ra_q.size() != 0 || wa_q.size() != 0) $display("[TB] FAIL zero%0d_activity: got reads=%0d writes=%0d expected 0/0", k, ra_q.size(), wa_q.size()); else passes++;
        end
    endtask

    task automatic test_busy_en();
        int cyc;
        fill_src();
        start_load(1, 2, 2, 1, 4, 4, 1'b0);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done(3, 40, cyc);
        checks++; if (cyc != 6) $display("[TB] FAIL busy_done_cycle: got %0d expected 6", cyc); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL busy_no_restart: got done=%b expected 1", done); else passes++;
        checks++; if (wa_q.size() != 4) $display("[TB] FAIL busy_write_count: got %0d expected 4", wa_q.size()); else passes++;
    endtask

    task automatic test_back_to_back();
        int cyc, got;
        fill_src();
        build_expected(1, 2, 2, 1, 4, 4);
        start_load(1, 2, 2, 1, 4, 4, 1'b1);
        wait_done(1, 40, cyc);
        checks++; if (cyc != 6) $display("[TB] FAIL b2b_first_done: got %0d expected 6", cyc); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("[TB] FAIL b2b_restart: got done=%b expected 0", done); else passes++;
        en = 1'b0;
        wait_done(1, 40, cyc);
        checks++; if (cyc != 6) $display("[TB] FAIL b2b_second_done: got %0d expected 6", cyc); else passes++;
        checks++; if (wa_q.size() != 8) $display("[TB] FAIL b2b_write_count: got %0d expected 8", wa_q.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            got = (i < wa_q.size()) ? wa_q[i] : -1;
            checks++; if (got != exp_a[i % 4]) $display("[TB] FAIL b2b_wa[%0d]: got %0d expected %0d", i, got, exp_a[i % 4]); else passes++;
        end
    endtask

    task automatic test_reset_mid_load();
        int ea[4] = '{5, 6, 9, 10};
        int cyc, got, n_wr, n_rd;
        fill_src();
        start_load(1, 2, 2, 1, 4, 4, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (done !== 1'b1 || src_re !== 1'b0 || in_we !== 1'b0) $display("[TB] FAIL midrst_ctrl: got done=%b re=%b we=%b expected 1/0/0", done, src_re, in_we); else passes++;
        checks++; if (src_ra !== '0 || in_wa !== '0) $display("[TB] FAIL midrst_addr: got ra=%0d wa=%0d expected 0/0", src_ra, in_wa); else passes++;
        @(negedge clk);
        rst  = 1'b0;
        n_wr = wa_q.size();
        n_rd = ra_q.size();
        repeat (4) @(negedge clk);
        checks++; if (wa_q.size() != n_wr || ra_q.size() != n_rd) $display("[TB] FAIL midrst_abandon: got extra writes=%0d reads=%0d expected 0/0", wa_q.size() - n_wr, ra_q.size() - n_rd); else passes++;
        start_load(1, 2, 2, 1, 4, 4, 1'b0);
        wait_done(1, 40, cyc);
        checks++; if (cyc != 6) $display("[TB] FAIL midrst_reload_done: got %0d expected 6", cyc); else passes++;
        checks++; if (wa_q.size() != 4) $display("[TB] FAIL midrst_reload_count: got %0d expected 4", wa_q.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            got = (i < wa_q.size()) ? wa_q[i] : -1;
            checks++; if (got != ea[i]) $display("[TB] FAIL midrst_wa[%0d]: got %0d expected %0d", i, got, ea[i]); else passes++;
            got = (i < wd_q.size()) ? wd_q[i] : -1;
            checks++; if (got != int'(src_mem[i])) $display("[TB] FAIL midrst_wd[%0d]: got %0d expected %0d", i, got, src_mem[i]); else passes++;
        end
    endtask

    task automatic test_random();
        int mn, rn, cn, pn, n, cyc, got, bad_a, bad_d, bad_r;
        for (int t = 0; t < 8; t++) begin
            mn = $urandom_range(1, 3);
            rn = $urandom_range(1, 4);
            cn = $urandom_range(1, 5);
            pn = $urandom_range(0, 2);
            n  = mn * rn * cn;
            fill_src();
            build_expected(mn, rn, cn, pn, rn + 2 * pn, cn + 2 * pn);
            start_load(mn, rn, cn, pn, rn + 2 * pn, cn + 2 * pn, 1'b0);
            wait_done(1, n + 20, cyc);
            checks++; if (cyc != n + 2) $display("[TB] FAIL rand%0d_done_cycle: got %0d expected %0d", t, cyc, n + 2); else passes++;
            checks++; if (wa_q.size() != n) $display("[TB] FAIL rand%0d_write_count: got %0d expected %0d", t, wa_q.size(), n); else passes++;
            bad_a = 0;
            bad_d = 0;
            bad_r = 0;
            for (int i = 0; i < n; i++) begin
                got = (i < ra_q.size()) ? ra_q[i] : -1;
                if (got != i) bad_r++;
                got = (i < wa_q.size()) ? wa_q[i] : -1;
                if (got != exp_a[i]) bad_a++;
                got = (i < wd_q.size()) ? wd_q[i] : -1;
                if (got != exp_d[i]) bad_d++;
            end
            checks++; if (bad_r != 0) $display("[TB] FAIL rand%0d_read_addr: got %0d wrong expected 0 wrong", t, bad_r); else passes++;
            checks++; if (bad_a != 0) $display("[TB] FAIL rand%0d_write_addr: got %0d wrong expected 0 wrong (M=%0d R=%0d C=%0d P=%0d)", t, bad_a, mn, rn, cn, pn); else passes++;
            checks++; if (bad_d != 0) $display("[TB] FAIL rand%0d_write_data: got %0d wrong expected 0 wrong", t, bad_d); else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        en     = 1'b0;
        M      = '0;
        R      = '0;
        C      = '0;
        P      = '0;
        nIR    = '0;
        nIC    = '0;
        test_reset();
        test_basic();
        test_multi_map();
        test_wrap();
        test_zero_size();
        test_busy_en();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
